// File: rtl/binarize_frame.sv
// ---------------------------------------------------------------------------
// binarize_frame
//   Captures one camera frame as a 1-bit-per-pixel image (gray > threshold),
//   then replays it as a gap-free stream of N = IMG_COL*IMG_ROW bits and waits
//   for the downstream consumer to signal completion before arming again.
//
//   Build option: define BINARIZE_INVERT_EN to mark dark pixels instead
//   (bit = gray < threshold). Nothing else changes.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_fval       camera frame-valid level
//   i_dval       camera pixel strobe (pixel taken when i_fval & i_dval)
//   i_r/i_g/i_b  pixel colour, DATA_W bits each
//   i_thresh     gray threshold, sampled with every accepted pixel
//   i_done       downstream completion pulse, honoured only while waiting
//   o_valid      high for exactly N consecutive cycles per replayed frame
//   o_seq        replayed binary pixel (meaningful while o_valid)
//   o_err        one-cycle pulse when a short frame is discarded
//   o_drop_cnt   saturating count of frames that arrived while busy
// ---------------------------------------------------------------------------
module binarize_frame #(
    parameter int IMG_COL = 640,
    parameter int IMG_ROW = 480,
    parameter int DATA_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fval,
    input  logic              i_dval,
    input  logic [DATA_W-1:0] i_r,
    input  logic [DATA_W-1:0] i_g,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_thresh,
    input  logic              i_done,
    output logic              o_valid,
    output logic              o_seq,
    output logic              o_err,
    output logic [7:0]        o_drop_cnt
);

    localparam int N  = IMG_COL * IMG_ROW;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    // Counters never hold N itself: the Nth accept/read is detected at N-1,
    // so AW bits suffice even when N is a power of two.
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_PLAY,
        S_WAIT_DONE
    } state_t;

    state_t          state, state_d;
    logic            fval_q;
    logic [AW-1:0]   wr_cnt, wr_cnt_d;
    logic [AW-1:0]   rd_cnt, rd_cnt_d;
    logic [AW-1:0]   wr_addr;
    logic            wr_en, rd_en, err_d, drop_inc;
    logic            rise;
    logic            pix_bit;
    logic [DATA_W+1:0] gray_sum;
    logic [DATA_W-1:0] gray;
    logic            mem [0:N-1];

    assign rise = i_fval & ~fval_q;

    // (R + 2G + B) at DATA_W+2 bits; dropping the two LSBs yields DATA_W bits.
    assign gray_sum = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
    assign gray     = gray_sum[DATA_W+1:2];

`ifdef BINARIZE_INVERT_EN
    assign pix_bit = (gray < i_thresh);
`else
    assign pix_bit = (gray > i_thresh);
`endif

    // ---------------- state / counter registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            fval_q     <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            o_valid    <= 1'b0;
            o_seq      <= 1'b0;
            o_err      <= 1'b0;
            o_drop_cnt <= 8'd0;
        end else begin
            state   <= state_d;
            fval_q  <= i_fval;
            wr_cnt  <= wr_cnt_d;
            rd_cnt  <= rd_cnt_d;
            // One-cycle read latency: data for the address issued now shows
            // up together with o_valid on the next cycle.
            o_valid <= rd_en;
            o_seq   <= rd_en & mem[rd_cnt];
            o_err   <= err_d;
            if (drop_inc && o_drop_cnt != 8'hFF)
                o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    // Frame store: contents are never cleared, only overwritten.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_addr] <= pix_bit;
    end

    // ---------------- next-state / control ----------------
    always_comb begin
        state_d  = state;
        wr_cnt_d = wr_cnt;
        rd_cnt_d = rd_cnt;
        wr_addr  = wr_cnt;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        err_d    = 1'b0;
        drop_inc = 1'b0;

        case (state)
            S_IDLE: begin
                // Only a fresh rising edge arms capture; a frame already in
                // flight (i_fval high with no edge) is left alone.
                if (rise) begin
                    wr_addr  = '0;
                    wr_cnt_d = '0;
                    state_d  = S_CAPTURE;
                    if (i_dval) begin
                        wr_en = 1'b1;
                        if (LAST == '0) begin
                            rd_cnt_d = '0;
                            state_d  = S_PLAY;
                        end else begin
                            wr_cnt_d = AW'(1);
                        end
                    end
                end
            end

            S_CAPTURE: begin
                if (!i_fval) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (i_dval) begin
                    wr_en = 1'b1;
                    // Frame complete: play straight away; the rest of this
                    // frame is ignored because no further writes happen.
                    if (wr_cnt == LAST) begin
                        rd_cnt_d = '0;
                        state_d  = S_PLAY;
                    end else begin
                        wr_cnt_d = wr_cnt + AW'(1);
                    end
                end
            end

            S_PLAY: begin
                rd_en    = 1'b1;
                drop_inc = rise;
                if (rd_cnt == LAST) begin
                    rd_cnt_d = '0;
                    state_d  = S_WAIT_DONE;
                end else begin
                    rd_cnt_d = rd_cnt + AW'(1);
                end
            end

            S_WAIT_DONE: begin
                drop_inc = rise;
                if (i_done)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_binarize_frame.sv
// ---------------------------------------------------------------------------
// tb_binarize_frame
//   Randomised and directed frames against a reference model of the
//   binarisation rule. Expected bits go into a queue as stimulus is issued;
//   a monitor on the falling edge pops and compares whenever o_valid is high
//   and checks each burst is exactly N long and o_err is single-cycle.
// ---------------------------------------------------------------------------
module tb_binarize_frame;

    localparam int IMG_COL = 4;
    localparam int IMG_ROW = 3;
    localparam int N       = IMG_COL * IMG_ROW;
    localparam int DATA_W  = 12;

    logic              i_clk, i_rst_n, i_fval, i_dval, i_done;
    logic [DATA_W-1:0] i_r, i_g, i_b, i_thresh;
    logic              o_valid, o_seq, o_err;
    logic [7:0]        o_drop_cnt;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int exp_err = 0;
    int n_pop = 0;
    int run = 0;
    bit err_prev = 0;
    bit exp_q[$];

    binarize_frame #(.IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .DATA_W(DATA_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_fval(i_fval), .i_dval(i_dval),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_thresh(i_thresh), .i_done(i_done),
        .o_valid(o_valid), .o_seq(o_seq), .o_err(o_err), .o_drop_cnt(o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            run      = 0;
            err_prev = 0;
        end else begin
            if (o_valid) begin
                bit e;
                run++;
                n_pop++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: o_valid=1 o_seq=%0b, no pixel expected", o_seq);
                end else begin
                    e = exp_q.pop_front();
                    if (o_seq !== e) begin
                        errors++;
                        $display("FAIL seq[%0d]: got %0b expected %0b", n_pop - 1, o_seq, e);
                    end
                end
            end else if (run != 0) begin
                checks++;
                if (run != N) begin
                    errors++;
                    $display("FAIL burst_len: got %0d expected %0d", run, N);
                end
                run = 0;
            end
            if (o_err) begin
                err_seen++;
                if (err_prev) begin
                    errors++;
                    $display("FAIL err_width: o_err high for more than one cycle");
                end
            end
            err_prev = o_err;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // kind: 0 random, 1 all 200/th100, 2 alternating 50/150, 3 alternating 100/50
    task automatic drive_frame(input int npix, input int gap, input int kind);
        int gv, gray, th;
        bit e;
        i_fval = 1'b1;
        for (int i = 0; i < npix; i++) begin
            case (kind)
                1: begin gv = 200; th = 100; end
                2: begin gv = (i % 2) ? 150 : 50; th = 100; end
                3: begin gv = (i % 2) ? 50 : 100; th = 100; end
                default: begin gv = -1; th = int'($urandom_range(0, 4095)); end
            endcase
            if (gv < 0) begin
                i_r = DATA_W'($urandom_range(0, 4095));
                i_g = DATA_W'($urandom_range(0, 4095));
                i_b = DATA_W'($urandom_range(0, 4095));
            end else begin
                i_r = DATA_W'(gv); i_g = DATA_W'(gv); i_b = DATA_W'(gv);
            end
            i_thresh = DATA_W'(th);
            gray = (int'(i_r) + 2 * int'(i_g) + int'(i_b)) / 4;
`ifdef BINARIZE_INVERT_EN
            e = (gray < th);
`else
            e = (gray > th);
`endif
            if (npix >= N && i < N) exp_q.push_back(e);
            i_dval = 1'b1;
            tick();
            i_dval = 1'b0;
            repeat (gap) tick();
        end
        i_fval = 1'b0;
        tick();
    endtask

    // Wait until every expected pixel has been replayed, then optionally
    // release the block with i_done.
    task automatic wait_play(input bit send_done);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL play_timeout: %0d pixels never replayed", exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
        if (send_done) begin
            i_done = 1'b1;
            tick();
            i_done = 1'b0;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        i_rst_n = 1'b0; i_fval = 1'b0; i_dval = 1'b0; i_done = 1'b0;
        i_r = '0; i_g = '0; i_b = '0; i_thresh = '0;
        repeat (3) tick();
        check("rst_valid", o_valid, 0);
        check("rst_seq", o_seq, 0);
        check("rst_err", o_err, 0);
        check("rst_drop", o_drop_cnt, 0);
        i_rst_n = 1'b1;
        tick();

        // Bright frame, contiguous pixels.
        drive_frame(N, 0, 1);
        wait_play(1);

        // Alternating gray, one strobe every three cycles.
        drive_frame(N, 2, 2);
        wait_play(1);

        // Random content, random pacing, some frames overlong.
        for (int k = 0; k < 4; k++) begin
            drive_frame(N + int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
            wait_play(1);
        end

        // Short frame: discarded with an error pulse, nothing replayed.
        exp_err++;
        drive_frame(7, 0, 0);
        repeat (4) tick();
        check("short_err", err_seen, exp_err);
        drive_frame(N, 1, 0);
        wait_play(1);
        check("err_count_after_full", err_seen, exp_err);

        // Frame that is already running when the block goes idle is skipped.
        drive_frame(N, 0, 0);
        wait_play(0);
        i_fval = 1'b1;
        tick();
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            i_dval = 1'b1;
            tick();
        end
        i_dval = 1'b0;
        i_fval = 1'b0;
        repeat (20) tick();
        check("drop_inprogress", o_drop_cnt, 1);
        check("err_inprogress", err_seen, exp_err);

        // Drop counter saturation while waiting for i_done.
        drive_frame(N, 0, 0);
        wait_play(0);
        for (int i = 0; i < 300; i++) begin
            i_fval = 1'b1;
            tick();
            i_fval = 1'b0;
            tick();
            if (i == 2) check("drop_3", o_drop_cnt, 4);
        end
        tick();
        check("drop_sat", o_drop_cnt, 255);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        tick();
        drive_frame(N, 0, 0);
        wait_play(1);

        // Reset in the middle of replay.
        drive_frame(N, 0, 1);
        base = n_pop;
        for (int t = 0; t < 100 && n_pop < base + 5; t++) tick();
        check("reached_play5", n_pop - base, 5);
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", o_valid, 0);
        check("rst_mid_drop", o_drop_cnt, 0);
        exp_q.delete();
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        base = n_pop;
        drive_frame(N, 0, 2);
        wait_play(1);
        check("post_rst_pixels", n_pop - base, N);

        // Threshold boundary: gray equal to threshold, and gray below it.
        drive_frame(N, 0, 3);
        wait_play(1);
        check("final_err", err_seen, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
